rs232_block_tx: RTL

Transmit-side stage of the RS-232/AES link. Accepts one 64-bit block over a valid/ready handshake and serialises it on the `TX` line as a framed byte stream: STX byte 0x02, then 8 payload bytes, each 8N1. It sits downstream of the block producer (the AES result or the 64-bit receive buffer) and drives the same `TX` pin the receive side expects, using the same byte framing convention.

---
 rtl/rs232_block_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rs232_block_tx.sv
// Serialises one accepted 64-bit block as STX + 8 payload bytes (MSB byte first), each 8N1.
// Define RS232_TX_CHKSUM_EN to append an XOR-of-payload checksum byte to every frame.
module rs232_block_tx #(
   parameter int unsigned CLKS_PER_BIT = 44,
   parameter logic [7:0]  STX_BYTE     = 8'h02
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] blk_data,
   input  logic        blk_valid,
   output logic        blk_ready,
   output logic        TX,
   output logic        busy
);

   localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
`ifdef RS232_TX_CHKSUM_EN
   localparam logic [3:0]  LastByte = 4'd9;
`else
   localparam logic [3:0]  LastByte = 4'd8;
`endif

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [3:0]  byte_q, byte_d;
   logic [63:0] buf_q, buf_d;
   logic [7:0]  cur_byte;
   logic        baud_done;
`ifdef RS232_TX_CHKSUM_EN
   logic [7:0]  chk_q, chk_d;
`endif

   assign baud_done = (baud_q == BaudLast);
   assign busy      = ~blk_ready;

   // Payload bytes are shifted out of the top of buf_q, so the active one is always [63:56].
   always_comb begin
      cur_byte = buf_q[63:56];
      if (byte_q == 4'd0) begin
         cur_byte = STX_BYTE;
      end
`ifdef RS232_TX_CHKSUM_EN
      else if (byte_q == LastByte) begin
         cur_byte = chk_q;
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      buf_d     = buf_q;
`ifdef RS232_TX_CHKSUM_EN
      chk_d     = chk_q;
`endif
      blk_ready = 1'b0;
      TX        = 1'b1;
      unique case (state_q)
         StIdle: begin
            blk_ready = 1'b1;
            if (blk_valid) begin
               buf_d   = blk_data;
               byte_d  = 4'd0;
               bit_d   = 3'd0;
               baud_d  = 16'd0;
`ifdef RS232_TX_CHKSUM_EN
               chk_d   = 8'h00;
`endif
               state_d = StStart;
            end
         end
         StStart: begin
            TX = 1'b0;
            if (baud_done) begin
               baud_d  = 16'd0;
               bit_d   = 3'd0;
               state_d = StData;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         StData: begin
            TX = cur_byte[bit_q];
            if (baud_done) begin
               baud_d = 16'd0;
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         StStop: begin
            if (baud_done) begin
               baud_d = 16'd0;
               if (byte_q != 4'd0) begin
                  buf_d = {buf_q[55:0], 8'h00};
`ifdef RS232_TX_CHKSUM_EN
                  chk_d = chk_q ^ buf_q[63:56];
`endif
               end
               if (byte_q == LastByte) begin
                  byte_d  = 4'd0;
                  state_d = StIdle;
               end else begin
                  byte_d  = byte_q + 4'd1;
                  state_d = StStart;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         byte_q  <= 4'd0;
         buf_q   <= 64'd0;
`ifdef RS232_TX_CHKSUM_EN
         chk_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         buf_q   <= buf_d;
`ifdef RS232_TX_CHKSUM_EN
         chk_q   <= chk_d;
`endif
      end
   end

endmodule
